// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- bundle of requester-side and transmitter-side signals
// around uart_tx_arbiter.
//
// Parameter:
//   N_REQ        number of byte producers (2..8)
// Signals (names kept from the original flat port list):
//   i_req        [N_REQ]    per-requester byte valid, held until o_ack
//   i_data       [8*N_REQ]  requester k's byte on bits [8k+7:8k]
//   i_last       [N_REQ]    per-requester end-of-packet flag
//   o_ack        [N_REQ]    one-hot 1-cycle pulse: byte taken
//   o_sent       [N_REQ]    one-hot 1-cycle pulse: byte fully on the line
//   o_grant_id   [ID_W]     requester currently owning the transmitter
//   o_active                high from accept until o_sent
//   o_tx_data    [8]        byte to uart_tx i_data
//   o_tx_start              1-cycle start pulse to uart_tx i_tx_start
//   i_tx_busy               uart_tx o_tx_busy
//   i_tx_done               uart_tx o_tx_done
// Modports: slave = arbiter side, master = requester/transmitter side.

interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_last;
  logic [N_REQ-1:0]   o_ack;
  logic [N_REQ-1:0]   o_sent;
  logic [ID_W-1:0]    o_grant_id;
  logic               o_active;
  logic [7:0]         o_tx_data;
  logic               o_tx_start;
  logic               i_tx_busy;
  logic               i_tx_done;

  modport slave (
    input  i_req, i_data, i_last, i_tx_busy, i_tx_done,
    output o_ack, o_sent, o_grant_id, o_active, o_tx_data, o_tx_start
  );

  modport master (
    output i_req, i_data, i_last, i_tx_busy, i_tx_done,
    input  o_ack, o_sent, o_grant_id, o_active, o_tx_data, o_tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin arbiter/sequencer sharing one uart_tx
// between N_REQ byte producers. One byte is accepted from the winning
// requester, launched with a single-cycle start pulse, and the next grant
// waits for the transmitter's done pulse.
//
// Ports:
//   i_clk   system clock
//   i_rst   synchronous active-high reset
//   bus     uart_tx_arbiter_if.slave (requester handshake + uart_tx link)
//
// Optional build macro UART_ARB_LOCK_EN: packet lock. A byte accepted with
// i_last=0 locks the arbiter to that requester until a byte with i_last=1
// has been sent; only then does the round-robin pointer advance. Without
// the macro i_last is ignored and round-robin applies on every byte.
//
// All outputs are registered. Overhead per byte is two cycles beyond the
// transmitter frame: done in D, o_sent in D+1, earliest next start in D+2.

module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int          ID_W = $clog2(N_REQ);
  localparam int unsigned NR   = N_REQ;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    WAIT_DONE = 2'd1,
    REPORT    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  sent_q, sent_d;
  logic              active_q, active_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

`ifdef UART_ARB_LOCK_EN
  logic              last_q, last_d;
  logic              lock_q, lock_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
`else
  logic              unused_last;
  assign unused_last = ^bus.i_last;
`endif

  logic [N_REQ-1:0]  elig;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  int unsigned       cand;
  logic              accept;
  logic              done_ev;
  logic [ID_W-1:0]   ptr_adv;

  // Pointer value that gives the last winner lowest priority next time.
  assign ptr_adv = (grant_q == ID_W'(NR - 1)) ? '0 : grant_q + 1'b1;

  // ---------------------------------------------------------------------------
  // State register (plus registered outputs and datapath)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      sent_q     <= '0;
      active_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      last_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      sent_q     <= sent_d;
      active_q   <= active_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef UART_ARB_LOCK_EN
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including the round-robin search
  // ---------------------------------------------------------------------------
  always_comb begin
    elig = bus.i_req;
`ifdef UART_ARB_LOCK_EN
    if (lock_q) begin
      elig            = '0;
      elig[lock_id_q] = bus.i_req[lock_id_q];
    end
`endif

    // Search ascending from ptr, wrapping modulo N_REQ; first hit wins.
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NR) begin
        cand = cand - NR;
      end
      if (!win_found && elig[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end

    // REPORT arbitrates like ARB: ptr/lock were already updated on the done
    // edge, so the next start can follow the done pulse by two cycles.
    accept  = (state_q != WAIT_DONE) && win_found && !bus.i_tx_busy;
    done_ev = (state_q == WAIT_DONE) && bus.i_tx_done;

    state_d = state_q;
    case (state_q)
      ARB, REPORT: state_d = accept ? WAIT_DONE : ARB;
      WAIT_DONE:   state_d = done_ev ? REPORT : WAIT_DONE;
      default:     state_d = ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d      = '0;
    sent_d     = '0;
    tx_start_d = 1'b0;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    active_d   = active_q;
    ptr_d      = ptr_q;
`ifdef UART_ARB_LOCK_EN
    last_d     = last_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
`endif

    if (accept) begin
      ack_d[win_id] = 1'b1;
      tx_start_d    = 1'b1;
      grant_d       = win_id;
      active_d      = 1'b1;
      for (int unsigned k = 0; k < NR; k++) begin
        if (win_id == ID_W'(k)) begin
          tx_data_d = bus.i_data[8*k +: 8];
        end
      end
`ifdef UART_ARB_LOCK_EN
      last_d = bus.i_last[win_id];
      if (!bus.i_last[win_id]) begin
        lock_d    = 1'b1;
        lock_id_d = win_id;
      end
`endif
    end

    if (done_ev) begin
      sent_d[grant_q] = 1'b1;
      active_d        = 1'b0;
`ifdef UART_ARB_LOCK_EN
      // Mid-packet bytes keep both the lock and the pointer.
      if (last_q) begin
        lock_d = 1'b0;
        ptr_d  = ptr_adv;
      end
`else
      ptr_d = ptr_adv;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_ack      = ack_q;
  assign bus.o_sent     = sent_q;
  assign bus.o_grant_id = grant_q;
  assign bus.o_active   = active_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  ack_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(ack_q));
  sent_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(sent_q));
  ack_with_start: assert property (@(posedge i_clk) disable iff (i_rst)
    (ack_q != '0) == tx_start_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter. The stimulus process
// drives requesters and a simple transmitter stand-in; a reference model of
// the arbitration rules predicts every ack and sent pulse and queues it with
// the cycle it is due. An independent monitor pops and compares.

module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct {
    int unsigned due;
    int unsigned id;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus state
  byte_t       src_q[N][$];
  logic [N-1:0] consumed;
  bit          rst_drv   = 1'b1;
  bit          rand_mode = 1'b0;
  bit          hold_all  = 1'b1;
  int unsigned frame_min = 3;
  int unsigned frame_max = 6;
  int unsigned tx_cnt    = 0;
  int unsigned ext_busy  = 0;
  bit          mon_on    = 1'b0;

  // Reference model state
  bit          m_free;
  int unsigned m_ptr;
  int unsigned m_grant;
  logic [7:0]  m_data;
  logic        m_last;
`ifdef UART_ARB_LOCK_EN
  bit          m_lock_v;
  int unsigned m_lock_id;
`endif

  exp_t ack_q[$];
  exp_t sent_q[$];

  task automatic model_reset();
    m_free   = 1'b1;
    m_ptr    = 0;
    m_grant  = 0;
    m_data   = '0;
    m_last   = 1'b0;
`ifdef UART_ARB_LOCK_EN
    m_lock_v  = 1'b0;
    m_lock_id = 0;
`endif
    consumed = '0;
    tx_cnt   = 0;
    ext_busy = 0;
    ack_q.delete();
    sent_q.delete();
    for (int k = 0; k < N; k++) src_q[k].delete();
  endtask

  function automatic bit idle();
    bit r;
    r = m_free && tx_cnt == 0 && ext_busy == 0 && ack_q.size() == 0 && sent_q.size() == 0;
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  // One clock cycle of stimulus, driven at the falling edge.
  task automatic drive_cycle();
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   elig;
    logic           busy;
    logic           done;
    bit             found;
    int unsigned    w;
    int unsigned    len;
    @(negedge clk);
    req = '0; data = '0; last = '0; busy = 1'b0; done = 1'b0;
    if (rst_drv) begin
      model_reset();
      rst = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (consumed[k] && src_q[k].size() != 0) src_q[k].delete(0);
      end
      consumed = '0;

      if (rand_mode) begin
        for (int k = 0; k < N; k++) begin
          if (src_q[k].size() == 0 && $urandom_range(5) == 0) begin
            len = $urandom_range(3, 1);
            for (int unsigned j = 0; j < len; j++)
              src_q[k].push_back('{d: 8'($urandom), l: (j == len - 1)});
          end
        end
      end

      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() != 0) begin
          req[k]          = hold_all || ($urandom_range(7) != 0);
          data[8*k +: 8]  = src_q[k][0].d;
          last[k]         = src_q[k][0].l;
        end else begin
          data[8*k +: 8]  = 8'($urandom);
          last[k]         = 1'($urandom);
        end
      end

      // Transmitter stand-in: busy from the start cycle, done pulse at the end.
      if (bus.o_tx_start) tx_cnt = $urandom_range(frame_max, frame_min);
      if (tx_cnt > 1) begin
        busy = 1'b1;
        tx_cnt--;
      end else if (tx_cnt == 1) begin
        done   = 1'b1;
        tx_cnt = 0;
      end
      if (ext_busy > 0) begin
        busy = 1'b1;
        ext_busy--;
      end else if (rand_mode && m_free && tx_cnt == 0 && $urandom_range(39) == 0) begin
        ext_busy = $urandom_range(20, 1);
      end

      // Reference model: grant when free and not busy, ascending from ptr.
      if (m_free && !busy) begin
        elig = req;
`ifdef UART_ARB_LOCK_EN
        if (m_lock_v) begin
          elig            = '0;
          elig[m_lock_id] = req[m_lock_id];
        end
`endif
        found = 1'b0;
        w     = 0;
        for (int unsigned i = 0; i < N; i++) begin
          if (!found && elig[(m_ptr + i) % N]) begin
            found = 1'b1;
            w     = (m_ptr + i) % N;
          end
        end
        if (found) begin
          ack_q.push_back('{due: cyc + 1, id: w, data: src_q[w][0].d});
          m_free      = 1'b0;
          m_grant     = w;
          m_data      = src_q[w][0].d;
          m_last      = src_q[w][0].l;
          consumed[w] = 1'b1;
`ifdef UART_ARB_LOCK_EN
          if (!m_last) begin
            m_lock_v  = 1'b1;
            m_lock_id = w;
          end
`endif
        end
      end
      if (done && !m_free) begin
        sent_q.push_back('{due: cyc + 1, id: m_grant, data: m_data});
`ifdef UART_ARB_LOCK_EN
        if (m_last) begin
          m_lock_v = 1'b0;
          m_ptr    = (m_grant + 1) % N;
        end
`else
        m_ptr = (m_grant + 1) % N;
`endif
        m_free = 1'b1;
      end
      rst = 1'b0;
    end
    bus.i_req     = req;
    bus.i_data    = data;
    bus.i_last    = last;
    bus.i_tx_busy = busy;
    bus.i_tx_done = done;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"},      32'(bus.o_ack),      32'd0);
    chk({tag, "_sent"},     32'(bus.o_sent),     32'd0);
    chk({tag, "_grant"},    32'(bus.o_grant_id), 32'd0);
    chk({tag, "_active"},   32'(bus.o_active),   32'd0);
    chk({tag, "_tx_data"},  32'(bus.o_tx_data),  32'd0);
    chk({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_drv = 1'b1;
    drive_cycle();
    rst_drv = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs(tag);
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n;
    logic        timed_out;
    n = 0;
    while (!idle() && n < bound) begin
      drive_cycle();
      n++;
    end
    drive_cycle();
    drive_cycle();
    timed_out = !idle();
    chk("idle_timeout", 32'(timed_out), 32'd0);
  endtask

  // Monitor: compares DUT outputs against whatever is due this cycle.
  initial begin : monitor
    exp_t         e;
    logic [N-1:0] ea;
    logic [N-1:0] es;
    logic         est;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        ea  = '0;
        est = 1'b0;
        if (ack_q.size() != 0 && ack_q[0].due == cyc) begin
          e        = ack_q.pop_front();
          ea[e.id] = 1'b1;
          est      = 1'b1;
          chk("tx_data",       32'(bus.o_tx_data),  32'(e.data));
          chk("grant_id",      32'(bus.o_grant_id), e.id);
          chk("active_on_ack", 32'(bus.o_active),   32'd1);
        end
        chk("ack",      32'(bus.o_ack),      32'(ea));
        chk("tx_start", 32'(bus.o_tx_start), 32'(est));
        es = '0;
        if (sent_q.size() != 0 && sent_q[0].due == cyc) begin
          e        = sent_q.pop_front();
          es[e.id] = 1'b1;
          chk("active_on_sent", 32'(bus.o_active),   32'd0);
          chk("tx_data_hold",   32'(bus.o_tx_data),  32'(e.data));
          chk("grant_hold",     32'(bus.o_grant_id), e.id);
        end
        chk("sent", 32'(bus.o_sent), 32'(es));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned n;
    bus.i_req     = '0;
    bus.i_data    = '0;
    bus.i_last    = '0;
    bus.i_tx_busy = 1'b0;
    bus.i_tx_done = 1'b0;
    model_reset();

    // Reset state
    rst_drv = 1'b1;
    repeat (3) drive_cycle();
    rst_drv = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mon_on = 1'b1;

    // Single byte A5 from requester 0
    src_q[0].push_back('{d: 8'hA5, l: 1'b1});
    wait_idle(100);

    // All four requesting from ptr=0, each sending its index twice
    pulse_reset("rst_rr");
    for (int k = 0; k < N; k++) begin
      src_q[k].push_back('{d: 8'(k), l: 1'b1});
      src_q[k].push_back('{d: 8'(k), l: 1'b1});
    end
    wait_idle(200);

    // Requester 2 while the transmitter is busy for 20 cycles
    ext_busy = 20;
    src_q[2].push_back('{d: 8'h5A, l: 1'b1});
    wait_idle(100);

    // Requester 2 sends a 3-byte packet; requester 0 joins one cycle later
    src_q[2].push_back('{d: 8'h21, l: 1'b0});
    src_q[2].push_back('{d: 8'h22, l: 1'b0});
    src_q[2].push_back('{d: 8'h23, l: 1'b1});
    drive_cycle();
    src_q[0].push_back('{d: 8'h01, l: 1'b1});
    src_q[0].push_back('{d: 8'h02, l: 1'b1});
    wait_idle(300);

    // Reset while waiting for a long frame, then 4'b1001 must start from ptr 0
    frame_min = 15;
    frame_max = 15;
    src_q[1].push_back('{d: 8'h3C, l: 1'b1});
    n = 0;
    while (m_free && n < 10) begin
      drive_cycle();
      n++;
    end
    chk("reset_case_accept", 32'(m_free), 32'd0);
    drive_cycle();
    drive_cycle();
    pulse_reset("rst_wait");
    frame_min = 3;
    frame_max = 6;
    src_q[0].push_back('{d: 8'hC0, l: 1'b1});
    src_q[3].push_back('{d: 8'hC3, l: 1'b1});
    wait_idle(100);
    src_q[3].push_back('{d: 8'h83, l: 1'b1});
    wait_idle(100);

    // Randomised traffic with request drops and external busy stalls
    frame_min = 2;
    frame_max = 8;
    rand_mode = 1'b1;
    hold_all  = 1'b0;
    repeat (3000) drive_cycle();
    rand_mode = 1'b0;
    hold_all  = 1'b1;
    wait_idle(1000);

    chk("ack_queue_empty",  32'(ack_q.size()),  32'd0);
    chk("sent_queue_empty", 32'(sent_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
